// File: rtl/target_hit_detector.sv
// target_hit_detector
// Synchronises and debounces the fire button, captures the crosshair and
// target on each new press, and emits one target_hit or target_miss pulse
// per accepted shot.
// Optional build macro: HIT_COOLDOWN_EN adds a post-shot lockout state
// (COOLDOWN_CYCLES long). Without it, EVAL returns straight to IDLE.
module target_hit_detector #(
  parameter int COORD_W         = 10,
  parameter int TGT_SIZE        = 16,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int COOLDOWN_CYCLES = 1000000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               fire_btn,
  input  logic [COORD_W-1:0] cross_x,
  input  logic [COORD_W-1:0] cross_y,
  input  logic [COORD_W-1:0] tgt_x,
  input  logic [COORD_W-1:0] tgt_y,
  input  logic               tgt_active,
  output logic               target_hit,
  output logic               target_miss,
  output logic               busy
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] EVAL     = 2'd1;
`ifdef HIT_COOLDOWN_EN
  localparam logic [1:0] COOLDOWN = 2'd2;
`endif

  // Counter only needs to reach DEBOUNCE_CYCLES-1.
  localparam int DEB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);

  // Box extent in one extra bit so boxes at the screen edge never wrap.
  localparam logic [COORD_W:0] SIZE_EXT = (COORD_W + 1)'(TGT_SIZE);

  logic             sync_a;
  logic             sync_b;
  logic             deb;
  logic             deb_prev;
  logic [DEB_W-1:0] deb_cnt;
  logic             press;
  logic [1:0]       state;

  logic [COORD_W-1:0] cap_cross_x;
  logic [COORD_W-1:0] cap_cross_y;
  logic [COORD_W-1:0] cap_tgt_x;
  logic [COORD_W-1:0] cap_tgt_y;
  logic               cap_active;
  logic [COORD_W:0]   x_limit;
  logic [COORD_W:0]   y_limit;
  logic               hit_now;

  // Two-flop synchroniser for the asynchronous button
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_a <= 1'b0;
      sync_b <= 1'b0;
    end else begin
      sync_a <= fire_btn;
      sync_b <= sync_a;
    end
  end

  // Debouncer: level follows the synchronised input only after a stable run
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb      <= 1'b0;
      deb_prev <= 1'b0;
      deb_cnt  <= '0;
    end else begin
      deb_prev <= deb;
      if (sync_b != deb) begin
        if (deb_cnt == DEB_LAST) begin
          deb     <= sync_b;
          deb_cnt <= '0;
        end else begin
          deb_cnt <= deb_cnt + 1'b1;
        end
      end else begin
        deb_cnt <= '0;
      end
    end
  end

  assign press = deb & ~deb_prev;

  // Capture shot operands on a press accepted in IDLE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_cross_x <= '0;
      cap_cross_y <= '0;
      cap_tgt_x   <= '0;
      cap_tgt_y   <= '0;
      cap_active  <= 1'b0;
    end else if (state == IDLE && press) begin
      cap_cross_x <= cross_x;
      cap_cross_y <= cross_y;
      cap_tgt_x   <= tgt_x;
      cap_tgt_y   <= tgt_y;
      cap_active  <= tgt_active;
    end
  end

  // Hit test on captured values only
  always_comb begin
    x_limit = {1'b0, cap_tgt_x} + SIZE_EXT;
    y_limit = {1'b0, cap_tgt_y} + SIZE_EXT;
    hit_now = cap_active
              && (cap_cross_x >= cap_tgt_x) && ({1'b0, cap_cross_x} < x_limit)
              && (cap_cross_y >= cap_tgt_y) && ({1'b0, cap_cross_y} < y_limit);
  end

`ifdef HIT_COOLDOWN_EN
  localparam int COOL_W = (COOLDOWN_CYCLES > 1) ? $clog2(COOLDOWN_CYCLES) : 1;
  localparam logic [COOL_W-1:0] COOL_LAST = COOL_W'(COOLDOWN_CYCLES - 1);
  logic [COOL_W-1:0] cool_cnt;

  // Shot FSM with registered result pulses and post-shot lockout
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      target_hit  <= 1'b0;
      target_miss <= 1'b0;
      cool_cnt    <= '0;
    end else begin
      target_hit  <= 1'b0;
      target_miss <= 1'b0;
      case (state)
        IDLE: begin
          if (press) state <= EVAL;
        end
        EVAL: begin
          target_hit  <= hit_now;
          target_miss <= ~hit_now;
          cool_cnt    <= '0;
          state       <= COOLDOWN;
        end
        COOLDOWN: begin
          // Presses seen here are simply not looked at, so they are dropped.
          if (cool_cnt == COOL_LAST) begin
            cool_cnt <= '0;
            state    <= IDLE;
          end else begin
            cool_cnt <= cool_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
`else
  // Lockout length is meaningless in this build.
  logic [31:0] unused_cooldown_cycles;
  assign unused_cooldown_cycles = 32'(COOLDOWN_CYCLES);

  // Shot FSM with registered result pulses, no lockout
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      target_hit  <= 1'b0;
      target_miss <= 1'b0;
    end else begin
      target_hit  <= 1'b0;
      target_miss <= 1'b0;
      case (state)
        IDLE: begin
          if (press) state <= EVAL;
        end
        EVAL: begin
          target_hit  <= hit_now;
          target_miss <= ~hit_now;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
`endif

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_target_hit_detector.sv
// Bench for target_hit_detector: directed scenarios followed by random shots,
// every cycle compared against a history-based model of the shot rules.
module tb_target_hit_detector;
  localparam int COORD_W = 10;
  localparam int TSIZE   = 16;
  localparam int D       = 4;
  localparam int C       = 8;
`ifdef HIT_COOLDOWN_EN
  localparam int C_EFF = C;
`else
  localparam int C_EFF = 0;
`endif
  localparam int HMAX = 8192;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               fire_btn = 1'b0;
  logic [COORD_W-1:0] cross_x = '0;
  logic [COORD_W-1:0] cross_y = '0;
  logic [COORD_W-1:0] tgt_x = '0;
  logic [COORD_W-1:0] tgt_y = '0;
  logic               tgt_active = 1'b0;
  logic               target_hit;
  logic               target_miss;
  logic               busy;

  int vectors = 0;
  int miscompares = 0;

  // Model state: sample histories indexed by edge number since reset.
  bit btn_h[HMAX];
  bit deb_h[HMAX];
  int k = 0;
  int accept_from = 0;
  int press_edge = -1000;
  int busy_until = -1000;
  bit hit_cap = 1'b0;
  bit exp_hit = 1'b0;
  bit exp_miss = 1'b0;
  bit exp_busy = 1'b0;

  target_hit_detector #(
    .COORD_W(COORD_W), .TGT_SIZE(TSIZE),
    .DEBOUNCE_CYCLES(D), .COOLDOWN_CYCLES(C)
  ) dut (
    .clk(clk), .rst_n(rst_n), .fire_btn(fire_btn),
    .cross_x(cross_x), .cross_y(cross_y),
    .tgt_x(tgt_x), .tgt_y(tgt_y), .tgt_active(tgt_active),
    .target_hit(target_hit), .target_miss(target_miss), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic bit btn_at(int i);
    return (i < 0) ? 1'b0 : btn_h[i];
  endfunction

  function automatic bit deb_at(int i);
    return (i < 0) ? 1'b0 : deb_h[i];
  endfunction

  function automatic bit ref_hit();
    int cx, cy, tx, ty;
    cx = int'(cross_x); cy = int'(cross_y);
    tx = int'(tgt_x);   ty = int'(tgt_y);
    return tgt_active && cx >= tx && cx < tx + TSIZE && cy >= ty && cy < ty + TSIZE;
  endfunction

  // Debounced level at edge k switches when the button, as seen through the
  // two-stage synchroniser, held the opposite value over the last D edges.
  task automatic model_edge();
    bit v, same, nd;
    btn_h[k] = fire_btn;
    nd = deb_at(k - 1);
    v = btn_at(k - 2);
    same = 1'b1;
    for (int j = k - D - 1; j <= k - 2; j++)
      if (btn_at(j) != v) same = 1'b0;
    if (same && v != nd) nd = v;
    deb_h[k] = nd;
    if (deb_at(k - 1) && !deb_at(k - 2) && k >= accept_from) begin
      press_edge  = k;
      hit_cap     = ref_hit();
      busy_until  = k + C_EFF;
      accept_from = busy_until + 2;
    end
    exp_hit  = (k == press_edge + 1) && hit_cap;
    exp_miss = (k == press_edge + 1) && !hit_cap;
    exp_busy = (k >= press_edge) && (k <= busy_until);
    if (k < HMAX - 1) k++;
  endtask

  task automatic model_reset();
    k = 0; accept_from = 0; press_edge = -1000; busy_until = -1000;
    exp_hit = 1'b0; exp_miss = 1'b0; exp_busy = 1'b0;
  endtask

  task automatic chk(input string tag, input logic obs, input logic expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s at edge %0d: observed=%b expected=%b", tag, k - 1, obs, expv);
    end
  endtask

  task automatic check_outputs();
    chk("target_hit", target_hit, exp_hit);
    chk("target_miss", target_miss, exp_miss);
    chk("busy", busy, exp_busy);
    chk("hit_miss_exclusive", target_hit & target_miss, 1'b0);
  endtask

  task automatic step(input bit b);
    fire_btn = b;
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic shot(input int hold, input int rel);
    repeat (hold) step(1'b1);
    repeat (rel) step(1'b0);
  endtask

  task automatic set_pos(input int tx, input int ty, input bit act, input int cx, input int cy);
    tgt_x = COORD_W'(tx); tgt_y = COORD_W'(ty); tgt_active = act;
    cross_x = COORD_W'(cx); cross_y = COORD_W'(cy);
  endtask

  // Pulls reset between edges; outputs must drop without waiting for a clock.
  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    model_reset();
    check_outputs();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int tx, ty, cx, cy, hold, rel;
    // Reset state
    @(posedge clk);
    #1;
    model_reset();
    check_outputs();
    @(negedge clk);
    rst_n = 1'b1;

    // Centre hit
    set_pos(100, 100, 1'b1, 108, 108);
    shot(10, 20);
    // Box edges
    set_pos(100, 100, 1'b1, 115, 115);
    shot(6, 20);
    set_pos(100, 100, 1'b1, 116, 108);
    shot(6, 20);
    set_pos(100, 100, 1'b1, 99, 108);
    shot(6, 20);
    // Screen-edge box and inactive target
    set_pos(630, 470, 1'b1, 639, 479);
    shot(6, 20);
    set_pos(100, 100, 1'b0, 108, 108);
    shot(6, 20);
    // Bounce: 2 high / 2 low for 20 cycles, then quiet
    set_pos(100, 100, 1'b1, 108, 108);
    repeat (5) begin
      step(1'b1); step(1'b1); step(1'b0); step(1'b0);
    end
    repeat (10) step(1'b0);
    // Early re-press during lockout, then a press after busy falls
    shot(5, 4);
    shot(10, 20);
    shot(6, 20);
    // Reset on the EVAL cycle, button held across release
    repeat (7) step(1'b1);
    do_reset();
    shot(10, 20);

    // Random shots with a moving crosshair, to exercise capture
    for (int n = 0; n < 40; n++) begin
      tx = int'($urandom_range(0, 639));
      ty = int'($urandom_range(0, 479));
      tgt_x = COORD_W'(tx); tgt_y = COORD_W'(ty);
      tgt_active = ($urandom_range(0, 4) != 0);
      hold = int'($urandom_range(1, 12));
      rel  = int'($urandom_range(1, 14));
      for (int s = 0; s < hold + rel; s++) begin
        cx = tx + int'($urandom_range(0, 24)) - 4;
        cy = ty + int'($urandom_range(0, 24)) - 4;
        cross_x = COORD_W'((cx < 0) ? 0 : cx);
        cross_y = COORD_W'((cy < 0) ? 0 : cy);
        step(s < hold);
      end
    end
    shot(0, 20);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/target_hit_detector.md
# target_hit_detector

Front-end stage that turns the player's raw fire button into a qualified, one-cycle `target_hit` pulse for the score counter. It synchronises and debounces the button, then captures the crosshair position on each new press. It compares that position against the active target's bounding box and emits exactly one `target_hit` or `target_miss` pulse per accepted shot. An optional cooldown window then rejects rapid re-fire.

## Interface
- `COORD_W`, 10: width of all screen coordinates (640x480 space).
- `TGT_SIZE`, 16: target box edge length in pixels (square box).
- `DEBOUNCE_CYCLES`, 50000: consecutive stable samples required to change the debounced level; must be ≥1.
- `COOLDOWN_CYCLES`, 1000000: post-shot lockout length in cycles; must be ≥1.

Ports:
- `clk`  in  1: system clock.
- `rst_n`  in  1: asynchronous, active-low reset.
- `fire_btn`  in  1: raw button, asynchronous to `clk`, active-high.
- `cross_x`, `cross_y`  in  COORD_W: crosshair position.
- `tgt_x`, `tgt_y`  in  COORD_W: target box top-left corner.
- `tgt_active`  in  1: target currently displayed.
- `target_hit`  out  1: one-cycle pulse on a qualified hit.
- `target_miss`  out  1: one-cycle pulse on a qualified miss.
- `busy`  out  1: high whenever FSM ≠ IDLE.

## Operation
- Synchroniser: two flops on `fire_btn`, producing `s`.
- Debouncer:
  - Counter increments on each edge where `s` ≠ `deb`.
  - Counter clears on any edge where `s` == `deb`.
  - When `s` ≠ `deb` and the counter is at DEBOUNCE_CYCLES−1, `deb` <= `s` and the counter clears.
- Press event: `deb` == 1 and `deb_prev` == 0. `deb_prev` is registered each edge.
- FSM states:
  - IDLE: on a press event, capture `cross_*`, `tgt_*` and `tgt_active` into registers, then go to EVAL. Otherwise stay in IDLE.
  - EVAL: compute hit from the captured values only. Assert `target_hit` if hit, else `target_miss`, for exactly one cycle. Go to COOLDOWN. Input changes after capture are ignored.
  - COOLDOWN: count COOLDOWN_CYCLES cycles, then go to IDLE. Press events arriving here are dropped, not queued.
- Hit rule: `tgt_active` && `cross_x` ≥ `tgt_x` && `cross_x` < `tgt_x`+TGT_SIZE, and the same test on y.
  - Sums are computed in COORD_W+1 bits so that boxes near the screen edge never wrap.
- `target_hit` and `target_miss` are never high in the same cycle.
- Releasing the button has no effect beyond re-arming the press detector.

## Timing
- Reset values: `target_hit`=0, `target_miss`=0, `busy`=0, FSM=IDLE, both synchroniser flops 0, `deb`=0, `deb_prev`=0, all counters 0.
- Latency, with edge 0 being the first edge at which `fire_btn` is sampled high and the button held stable:
  - `deb` rises at edge D+1 (D = DEBOUNCE_CYCLES).
  - Capture and transition to EVAL occur at edge D+2.
  - The output pulse is registered at edge D+3 and cleared at D+4.
- `busy` is high from edge D+2 through the end of COOLDOWN.
- Shot period: the next press is accepted no earlier than the edge at which the FSM is back in IDLE.
- Reset asserted mid-shot: outputs drop immediately and any pending pulse is lost.
- Button held through reset release: the debouncer starts at 0, so this is treated as a fresh press after D+2 edges.
- Glitch shorter than D samples: no `deb` change and no pulse.

## Configuration
- `HIT_COOLDOWN_EN` defined: COOLDOWN state and counter present, behaviour as above.
- `HIT_COOLDOWN_EN` undefined:
  - COOLDOWN state and counter are removed; EVAL goes straight to IDLE.
  - The next press can be accepted immediately, still limited by the debounce, since each press needs a release and a re-press.
  - `COOLDOWN_CYCLES` is ignored.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4, COOLDOWN_CYCLES=8, TGT_SIZE=16.
- Centre hit: target at (100,100), `tgt_active`=1, crosshair (108,108), press held 10 cycles → one `target_hit` pulse at edge 7 after the first sample, `target_miss` stays 0, `busy` high through COOLDOWN.
- Box edges: crosshair (115,115) → hit; crosshair (116,108) → miss; crosshair (99,108) → miss.
- Wrap and inactive target:
  - Target at (630,470), crosshair (639,479) → hit.
  - Any crosshair with `tgt_active`=0 → miss.
- Bounce: `fire_btn` toggled every 2 cycles for 20 cycles, then held 0 → no pulse on either output.
- Cooldown: second clean press accepted 3 cycles after the first pulse → dropped, no pulse. A press made after `busy` falls → pulse. Without `HIT_COOLDOWN_EN`, that same early second press (after release) → pulse.
- Reset: `rst_n` pulled low on the EVAL cycle → no pulse, all outputs 0. With the button held across release → one pulse 7 edges after the release.
